// File: rtl/pipe_stage_buf.sv
// Reusable inter-stage register: 2-entry skid buffer, valid/ready, flush, bubble control. Optional stats: PIPE_STAGE_BUF_STATS_EN.
// Latency: 1 cycle from accept to out_*; each entry parked in skid adds 1 cycle.
// Backpressure: in_ready comes only from the state register; one extra entry is absorbed into skid on a stall.
module pipe_stage_buf #(
    parameter int                DATA_W      = 32,
    parameter int                CTRL_W      = 16,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = {CTRL_W{1'b0}}
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [15:0]       stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] main_data, skid_data;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic              push, pop;
    logic              load_main_in, load_main_skid, load_skid;

    assign in_ready  = (state != ST_TWO);
    assign out_valid = (state != ST_EMPTY);
    assign out_data  = main_data;
    assign out_ctrl  = out_valid ? main_ctrl : BUBBLE_CTRL;
    assign occupancy = state;

    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready;

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (push) begin
                        load_main_in = 1'b1;
                        state_nxt    = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        load_main_in = 1'b1;
                    end else if (push) begin
                        load_skid = 1'b1;
                        state_nxt = ST_TWO;
                    end else if (pop) begin
                        state_nxt = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        load_main_skid = 1'b1;
                        state_nxt      = ST_ONE;
                    end
                end
                default: state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Payload registers hold their value when empty so out_data stays stable.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            main_data <= '0;
            main_ctrl <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
        end else begin
            if (load_main_in) begin
                main_data <= in_data;
                main_ctrl <= in_ctrl;
            end else if (load_main_skid) begin
                main_data <= skid_data;
                main_ctrl <= skid_ctrl;
            end
            if (load_skid) begin
                skid_data <= in_data;
                skid_ctrl <= in_ctrl;
            end
        end
    end

`ifdef PIPE_STAGE_BUF_STATS_EN
    logic [15:0] stall_q;

    // Counts stalled-output edges; only reset clears it, flush does not.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_q <= 16'h0000;
        end else if (out_valid && !out_ready && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'h0001;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised pipeline-stage register with a valid/ready handshake, a two-entry skid buffer, synchronous flush and bubble insertion. It replaces the fixed-field inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one reusable block. Payload and control are carried as two flat vectors, so each stage instance is sized by parameters. A stall downstream is absorbed without a combinational ready path, and an invalid slot always presents an inert control word.

## Interface
Parameters:
- DATA_W, 32: payload width (ALU result, store data, PC, …).
- CTRL_W, 16: control-field width (RegWrite, MemWrite, MemtoReg, WriteReg, load/save option, PCSrc, …).
- BUBBLE_CTRL, {CTRL_W{1'b0}}: control word presented whenever the output slot is empty. It must de-assert all write enables.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  block can accept an entry this cycle.
- in_data  in  DATA_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control.
- flush  in  1  synchronous kill of all held entries and of this cycle's input.
- out_valid  out  1  output entry present.
- out_ready  in  1  downstream consumes the entry this cycle.
- out_data  out  DATA_W  head payload.
- out_ctrl  out  CTRL_W  head control, or BUBBLE_CTRL when out_valid=0.
- occupancy  out  2  entries held (0..2).
- stall_cnt  out  16  saturating count of stall cycles (see Configuration).

## Operation
- Storage: a main register (head) and a skid register.
- State is EMPTY, ONE or TWO. occupancy is 0, 1 or 2 respectively.
- push = in_valid & in_ready & ~flush. pop = out_valid & out_ready.
- State transitions:
  - EMPTY: push loads main and moves to ONE.
  - ONE, push & ~pop: load skid, move to TWO.
  - ONE, pop & ~push: move to EMPTY.
  - ONE, push & pop: reload main, stay in ONE.
  - TWO: pop moves skid into main and goes to ONE. No push is possible.
  - Any state with flush: go to EMPTY. Both entries and this cycle's input are discarded. flush has priority over push and pop.
- Output decode:
  - in_ready = (state != TWO). It is decoded only from the state register, with no path from out_ready.
  - out_valid = (state != EMPTY).
  - out_data = main payload. It holds its last value when empty.
  - out_ctrl = main control when out_valid=1, else BUBBLE_CTRL.
- Ordering is strict FIFO. No entry is duplicated or reordered.
- Widths are pure pass-through. No arithmetic is performed on payload or control.

## Timing
- Reset (reset=0, asynchronous) sets:
  - state EMPTY, occupancy 0
  - out_valid 0, in_ready 1
  - out_data 0, out_ctrl BUBBLE_CTRL
  - skid cleared, stall_cnt 0
- Release of reset takes effect at the next rising edge.
- Latency: an entry accepted at edge N is visible on out_* after edge N, for one cycle of latency. The skid path adds one cycle per held entry.
- Throughput: 1 entry per cycle with out_ready held high.
- Downstream stall (out_ready=0) with occupancy 1: one further entry is accepted into skid. in_ready drops after that edge.
- Reset asserted mid-transfer: all held entries are lost and outputs return to reset values immediately, without waiting for a clock edge.
- flush with out_ready=1 in the same cycle: the head is still counted as consumed by downstream, but this block discards its own state.

## Configuration
- PIPE_STAGE_BUF_STATS_EN defined:
  - stall_cnt increments on every edge where out_valid & ~out_ready.
  - It saturates at 16'hFFFF.
  - It is cleared only by reset. flush does not clear it.
- Undefined: stall_cnt is tied to 16'h0000 and no counter logic is built. The port remains present so that instantiations are identical.

## Test plan
- Reset then stream: in_data 0x00000001..0x00000008 on consecutive cycles with out_ready=1. Required: out_data matches each value one cycle later, with occupancy 1 throughout and in_ready=1.
- Backpressure: push A=0x11, B=0x22 and C=0x33 while out_ready=0. Required: A and B accepted, occupancy 2, in_ready=0, C held upstream. After out_ready rises, outputs A, B, C appear in order with no duplicates.
- Flush: with occupancy 2 and in_valid=1 carrying 0x44, assert flush for one cycle. Required next cycle: occupancy 0, out_valid 0, out_ctrl=BUBBLE_CTRL, and 0x44 is never output.
- Simultaneous push and pop in ONE: head 0x55, push 0x66 with out_ready=1. Required: next cycle out_data=0x66 and occupancy stays 1.
- Async reset mid-stall: with occupancy 2, pull reset low between edges. Required: out_valid=0, occupancy=0, out_data=0, in_ready=1 immediately.
- With PIPE_STAGE_BUF_STATS_EN defined: hold out_valid=1 and out_ready=0 for 10 cycles. Required: stall_cnt=10. With the macro undefined, stall_cnt stays 0.
